camera_transmitter: RTL and testbench



---
 rtl/camera_transmitter.sv | 146 ++++++++++++++
 tb/tb_camera_transmitter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/camera_transmitter.sv
// Sensor-side video transmitter: fixed vs/hs frame timing that pulls pixels from a
// valid-qualified source and reports starved pixels through a per-frame sticky flag.
//   state     | meaning
//   ST_IDLE   | no frame, waiting for enable
//   ST_VSYNC  | vs pulse, vs_width cycles
//   ST_VFRONT | blank between vs fall and first line
//   ST_LINE   | active pixels, one consumed per cycle
//   ST_HBLANK | blank between lines
//   ST_VBACK  | blank after the last line, then next frame or idle
module camera_transmitter #(
    parameter int frame_lines = 1540,
    parameter int frame_width = 2300,
    parameter int vs_width    = 16,
    parameter int v_front     = 32,
    parameter int h_blank     = 64,
    parameter int v_back      = 128
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       enable,
    input  logic [9:0] pixel_in,
    input  logic       pixel_in_valid,
    output logic       pixel_in_ready,
    output logic [9:0] pixel_data,
    output logic       vs,
    output logic       hs,
    output logic       frame_active,
    output logic       underrun
);

    if (frame_lines < 1 || frame_lines > 4095 || frame_width < 1 || frame_width > 4095 ||
        vs_width < 1 || v_front < 1 || h_blank < 1 || v_back < 1 ||
        vs_width > 65536 || v_front > 65536 || h_blank > 65536 || v_back > 65536) begin : g_param_check
        $error("camera_transmitter: timing parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VFRONT,
        ST_LINE,
        ST_HBLANK,
        ST_VBACK
    } state_t;

    localparam logic [11:0] COL_LAST  = 12'(frame_width - 1);
    localparam logic [11:0] LINE_LAST = 12'(frame_lines - 1);
    localparam logic [15:0] VS_LOAD   = 16'(vs_width - 1);
    localparam logic [15:0] VF_LOAD   = 16'(v_front - 1);
    localparam logic [15:0] HB_LOAD   = 16'(h_blank - 1);
    localparam logic [15:0] VB_LOAD   = 16'(v_back - 1);

    state_t      state_q, state_d;
    logic [11:0] col_q;
    logic [11:0] line_q;
    logic [15:0] blank_q;
    logic [15:0] blank_load_d;
    logic        blank_done;
    logic        line_end;
    logic        vs_q, hs_q, frame_active_q, underrun_q, frame_err_q;
    logic [9:0]  pixel_data_q;

    assign blank_done     = (blank_q == 16'd0);
    assign line_end       = (col_q == COL_LAST);
    assign pixel_in_ready = (state_q == ST_LINE);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (enable) state_d = ST_VSYNC;
            ST_VSYNC:  if (blank_done) state_d = ST_VFRONT;
            ST_VFRONT: if (blank_done) state_d = ST_LINE;
            ST_LINE:   if (line_end) state_d = (line_q == LINE_LAST) ? ST_VBACK : ST_HBLANK;
            ST_HBLANK: if (blank_done) state_d = ST_LINE;
            ST_VBACK:  if (blank_done) state_d = enable ? ST_VSYNC : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        blank_load_d = 16'd0;
        case (state_d)
            ST_VSYNC:  blank_load_d = VS_LOAD;
            ST_VFRONT: blank_load_d = VF_LOAD;
            ST_HBLANK: blank_load_d = HB_LOAD;
            ST_VBACK:  blank_load_d = VB_LOAD;
            default:   blank_load_d = 16'd0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            col_q          <= '0;
            line_q         <= '0;
            blank_q        <= '0;
            vs_q           <= 1'b0;
            hs_q           <= 1'b0;
            frame_active_q <= 1'b0;
            underrun_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            pixel_data_q   <= '0;
        end else begin
            state_q <= state_d;

            if (state_d != state_q) begin
                blank_q <= blank_load_d;
            end else if (!blank_done) begin
                blank_q <= blank_q - 16'd1;
            end

            if (state_d == ST_VFRONT && state_q != ST_VFRONT) begin
                col_q  <= '0;
                line_q <= '0;
            end else if (state_q == ST_LINE) begin
                if (line_end) begin
                    col_q  <= '0;
                    line_q <= line_q + 12'd1;
                end else begin
                    col_q <= col_q + 12'd1;
                end
            end

            vs_q           <= (state_q == ST_VSYNC);
            hs_q           <= (state_q == ST_LINE);
            frame_active_q <= (state_q != ST_IDLE);
            pixel_data_q   <= (pixel_in_ready && pixel_in_valid) ? pixel_in : 10'h000;

            // At vs rise the flag carries over only if the frame just finished was starved.
            if (state_q == ST_VSYNC && !vs_q) begin
                underrun_q  <= frame_err_q;
                frame_err_q <= 1'b0;
            end else if (pixel_in_ready && !pixel_in_valid) begin
                underrun_q  <= 1'b1;
                frame_err_q <= 1'b1;
            end
        end
    end

    assign pixel_data   = pixel_data_q;
    assign vs           = vs_q;
    assign hs           = hs_q;
    assign frame_active = frame_active_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_camera_transmitter.sv
// Scoreboarded bench for camera_transmitter: ramp source drives a queue of expected
// pixels, a monitor pops on hs, and a timing checker measures vs/hs runs and frame period.
module tb_camera_transmitter;

    localparam int LINES = 4;
    localparam int WIDTH = 8;
    localparam int VSW   = 2;
    localparam int VFR   = 3;
    localparam int HBL   = 2;
    localparam int VBK   = 5;
    localparam int PERIOD = 48;

    logic       pclk = 1'b0;
    logic       reset;
    logic       enable;
    logic [9:0] pixel_in;
    logic       pixel_in_valid;
    logic       pixel_in_ready;
    logic [9:0] pixel_data;
    logic       vs, hs, frame_active, underrun;

    camera_transmitter #(
        .frame_lines(LINES), .frame_width(WIDTH), .vs_width(VSW),
        .v_front(VFR), .h_blank(HBL), .v_back(VBK)
    ) dut (
        .pclk(pclk), .reset(reset), .enable(enable),
        .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid), .pixel_in_ready(pixel_in_ready),
        .pixel_data(pixel_data), .vs(vs), .hs(hs),
        .frame_active(frame_active), .underrun(underrun)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [9:0] data;
        logic       ur;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    int   frame_no     = 0;
    int   pix_idx      = 0;
    int   starve_frame = -1;
    logic cur_ur       = 1'b0;
    logic frame_starve = 1'b0;
    logic drv_prev_vs  = 1'b0;
    logic tmon_off     = 1'b1;
    logic chk_period   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Source: ramp indexed by slot within the frame; one slot is starved on request.
    initial begin
        logic starve;
        pixel_in       = '0;
        pixel_in_valid = 1'b0;
        forever begin
            @(negedge pclk);
            if (vs && !drv_prev_vs) begin
                frame_no++;
                pix_idx      = 0;
                cur_ur       = frame_starve;
                frame_starve = 1'b0;
            end
            drv_prev_vs    = vs;
            starve         = (frame_no == starve_frame) && (pix_idx == 10);
            pixel_in       = 10'(pix_idx);
            pixel_in_valid = !starve;
            if (pixel_in_ready) begin
                if (starve) begin
                    cur_ur       = 1'b1;
                    frame_starve = 1'b1;
                end
                sb.push_back('{data: (starve ? 10'h000 : pixel_in), ur: cur_ur});
                pix_idx++;
            end
        end
    end

    // Monitor: pops one expectation per hs cycle.
    initial begin
        exp_t it;
        forever begin
            @(negedge pclk);
            if (hs) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: hs high with no pending pixel at %0t", $time);
                end else begin
                    it = sb.pop_front();
                    check("pixel_data", pixel_data, it.data);
                    check("underrun", underrun, it.ur);
                end
            end else begin
                check("blank_pixel", pixel_data, 0);
            end
        end
    end

    // Timing checker: run lengths, pulses per frame, period, vs/hs exclusivity.
    initial begin
        int vs_run = 0, hs_run = 0, hs_pulses = 0, period = 0;
        logic have_frame = 1'b0, prev_vs = 1'b0, prev_hs = 1'b0, prev_rdy = 1'b0;
        forever begin
            @(negedge pclk);
            if (tmon_off) begin
                vs_run = 0; hs_run = 0; hs_pulses = 0; period = 0; have_frame = 1'b0;
            end else begin
                period++;
                if (vs && hs) check("vs_hs_overlap", 1, 0);
                check("hs_follows_ready", hs, prev_rdy);
                if (vs) vs_run++;
                if (hs) hs_run++;
                if (vs && !prev_vs) begin
                    if (have_frame) begin
                        check("hs_pulses", hs_pulses, LINES);
                        if (chk_period) check("period", period, PERIOD);
                    end
                    have_frame = 1'b1;
                    period = 0;
                    hs_pulses = 0;
                end
                if (!vs && prev_vs) begin
                    check("vs_width", vs_run, VSW);
                    vs_run = 0;
                end
                if (!hs && prev_hs) begin
                    check("hs_width", hs_run, WIDTH);
                    hs_run = 0;
                    hs_pulses++;
                end
            end
            prev_vs  = vs;
            prev_hs  = hs;
            prev_rdy = pixel_in_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_frame(input int target, input string name);
        int n = 0;
        while (frame_no < target && n < 1000) begin
            @(negedge pclk);
            n++;
        end
        if (frame_no < target) check(name, frame_no, target);
    endtask

    initial begin
        int n, falls, tail, vs_cnt, fr;
        logic ph;
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_vs", vs, 0);
        check("rst_hs", hs, 0);
        check("rst_frame_active", frame_active, 0);
        check("rst_underrun", underrun, 0);
        check("rst_ready", pixel_in_ready, 0);
        check("rst_pixel", pixel_data, 0);
        reset = 1'b0;
        @(negedge pclk);
        check("idle_vs", vs, 0);

        // Start latency and three clean back-to-back frames.
        tmon_off = 1'b0;
        enable   = 1'b1;
        @(negedge pclk);
        check("start_vs_1cyc", vs, 0);
        @(negedge pclk);
        check("start_vs_2cyc", vs, 1);
        check("start_frame_active", frame_active, 1);
        chk_period = 1'b1;
        wait_frame(4, "wait_clean_frames");
        check("clean_underrun", underrun, 0);

        // Starve slot 10 of the next frame; flag must survive one more vs rise.
        starve_frame = frame_no + 1;
        wait_frame(starve_frame + 1, "wait_starve_next");
        check("underrun_held", underrun, 1);
        wait_frame(starve_frame + 2, "wait_starve_clear");
        check("underrun_cleared", underrun, 0);

        // Drop enable during line 2: frame must still finish.
        @(negedge pclk);
        n = 0;
        while (!(hs && pix_idx >= 18 && pix_idx < 24) && n < 200) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 200) check("wait_line2", pix_idx, 18);
        enable     = 1'b0;
        chk_period = 1'b0;
        falls = 0; tail = 0; ph = hs; n = 0;
        while (frame_active && n < 300) begin
            @(negedge pclk);
            n++;
            if (ph && !hs) falls++;
            if (hs) tail = 0;
            else if (frame_active) tail++;
            ph = hs;
        end
        check("drop_frame_end", frame_active, 0);
        check("drop_lines_left", falls, 2);
        check("drop_vback_tail", tail, VBK);
        vs_cnt = 0;
        repeat (60) begin
            @(negedge pclk);
            if (vs) vs_cnt++;
        end
        check("idle_no_vs", vs_cnt, 0);
        check("idle_ready", pixel_in_ready, 0);

        // Reset on the 5th hs cycle of line 1.
        enable = 1'b1;
        n = 0;
        while (!(hs && pixel_data == 10'd12) && n < 200) begin
            @(negedge pclk);
            n++;
        end
        if (n >= 200) check("wait_line1_px4", pixel_data, 12);
        tmon_off = 1'b1;
        reset    = 1'b1;
        @(negedge pclk);
        check("abort_hs", hs, 0);
        check("abort_vs", vs, 0);
        check("abort_ready", pixel_in_ready, 0);
        check("abort_frame_active", frame_active, 0);
        check("abort_pixel", pixel_data, 0);
        sb.delete();
        cur_ur       = 1'b0;
        frame_starve = 1'b0;
        reset    = 1'b0;
        tmon_off = 1'b0;
        @(negedge pclk);
        check("restart_vs_1cyc", vs, 0);
        @(negedge pclk);
        check("restart_vs_2cyc", vs, 1);
        @(negedge pclk);
        fr = frame_no;
        wait_frame(fr + 1, "wait_restart_frame");
        enable = 1'b0;
        n = 0;
        while (frame_active && n < 200) begin
            @(negedge pclk);
            n++;
        end
        check("final_frame_active", frame_active, 0);
        check("final_sb_drained", sb.size(), 0);
        check("final_underrun", underrun, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
